// File: rtl/fx2_fifo_writer.sv
// Moves the sample-multiplexer byte stream into a Cypress FX2 slave FIFO endpoint.
// Short packets are committed with PKTEND once the stream has been idle long enough.
module fx2_fifo_writer #(
   parameter logic [1:0] EP_ADDR       = 2'b10,
   parameter int         PKT_SIZE      = 512,
   parameter int         FLUSH_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       data_rdy,
   output logic       data_ack,
   input  logic       fx2_full_n,
   output logic [7:0] fx2_fd,
   output logic       fx2_slwr_n,
   output logic       fx2_pktend_n,
   output logic [1:0] fx2_fifoadr
);

   localparam int CW = $clog2(PKT_SIZE);
   localparam int TW = $clog2(FLUSH_TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(FLUSH_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      PKTEND,
      RECOVER
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] pkt_count, pkt_count_next;
   logic [TW-1:0] idle_timer, idle_timer_next;
   logic          pkt_pending;
   logic          timer_expired;
   logic          ack_int;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next      = state;
      pkt_count_next  = pkt_count;
      idle_timer_next = idle_timer;
      ack_int         = 1'b0;
      pkt_pending     = (pkt_count != '0);
      timer_expired   = pkt_pending && (idle_timer == TIMER_LAST);

      case (state)
         IDLE: begin
            if (data_rdy && fx2_full_n) begin
               ack_int    = 1'b1;
               state_next = WRITE;
            end else if (timer_expired && fx2_full_n) begin
               state_next = PKTEND;
            end
         end
         WRITE: begin
            // Power-of-two packet size: the counter wraps exactly where the FX2 auto-commits.
            pkt_count_next = pkt_count + CW'(1);
            state_next     = RECOVER;
         end
         PKTEND: begin
            pkt_count_next = '0;
            state_next     = RECOVER;
         end
         RECOVER: state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // The timer saturates at its last value, so a full endpoint parks the flush until it drains.
      if (ack_int || (state == IDLE && state_next == PKTEND) || !pkt_pending) begin
         idle_timer_next = '0;
      end else if (state == IDLE && !data_rdy && idle_timer != TIMER_LAST) begin
         idle_timer_next = idle_timer + TW'(1);
      end

      data_ack = ack_int && !reset;
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state        <= IDLE;
         pkt_count    <= '0;
         idle_timer   <= '0;
         fx2_fd       <= 8'h00;
         fx2_slwr_n   <= 1'b1;
         fx2_pktend_n <= 1'b1;
      end else begin
         state        <= state_next;
         pkt_count    <= pkt_count_next;
         idle_timer   <= idle_timer_next;
         if (ack_int) begin
            fx2_fd <= data;
         end
         fx2_slwr_n   <= (state_next != WRITE);
         fx2_pktend_n <= (state_next != PKTEND);
      end
   end

   assign fx2_fifoadr = EP_ADDR;

endmodule

// File: tb/tb_fx2_fifo_writer.sv
// Self-checking bench for fx2_fifo_writer: cycle vectors first, then multi-cycle sequences
// for record timing, packet wrap, FULL stalls, flush/data collision and reset mid-write.
module tb_fx2_fifo_writer;

   localparam int PKT_SIZE = 512;
   localparam int FT       = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data;
   logic       data_rdy;
   logic       data_ack;
   logic       fx2_full_n;
   logic [7:0] fx2_fd;
   logic       fx2_slwr_n;
   logic       fx2_pktend_n;
   logic [1:0] fx2_fifoadr;

   fx2_fifo_writer #(
      .EP_ADDR      (2'b10),
      .PKT_SIZE     (PKT_SIZE),
      .FLUSH_TIMEOUT(FT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data        (data),
      .data_rdy    (data_rdy),
      .data_ack    (data_ack),
      .fx2_full_n  (fx2_full_n),
      .fx2_fd      (fx2_fd),
      .fx2_slwr_n  (fx2_slwr_n),
      .fx2_pktend_n(fx2_pktend_n),
      .fx2_fifoadr (fx2_fifoadr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor: every strobe-low cycle observed mid-cycle.
   logic [7:0] wr_q[$];
   int         wr_cyc[$];
   int         pk_cyc[$];

   always @(negedge clk) begin
      if (fx2_slwr_n === 1'b0) begin
         wr_q.push_back(fx2_fd);
         wr_cyc.push_back(cyc);
      end
      if (fx2_pktend_n === 1'b0) pk_cyc.push_back(cyc);
   end

   typedef struct {
      logic       rst;
      logic [7:0] d;
      logic       rdy;
      logic       full_n;
      logic       ack;
      logic [7:0] fd;
      logic       slwr_n;
      logic       pktend_n;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      data_rdy = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic clear_mon();
      wr_q.delete();
      wr_cyc.delete();
      pk_cyc.delete();
   endtask

   // Offers a byte and returns the cycle in which it was acked (-1 if never).
   task automatic send_byte(input logic [7:0] b, output int ack_cyc);
      bit acked = 1'b0;
      int n     = 0;
      data     = b;
      data_rdy = 1'b1;
      ack_cyc  = -1;
      while (!acked && n < 20) begin
         @(negedge clk);
         if (data_ack === 1'b1) begin
            acked   = 1'b1;
            ack_cyc = cyc;
         end
         tick();
         n++;
      end
      if (!acked) check($sformatf("ack_timeout_%0h", b), 32'(acked), 32'd1);
   endtask

   task automatic wait_pktend(input int n_before, input int limit, output int pcyc);
      int n = 0;
      while (pk_cyc.size() <= n_before && n < limit) begin
         tick();
         n++;
      end
      pcyc = (pk_cyc.size() > n_before) ? pk_cyc[n_before] : -1;
   endtask

   function automatic int wr_at(input int k);
      return (k < wr_q.size()) ? int'(wr_q[k]) : -1;
   endfunction

   function automatic int wr_cyc_at(input int k);
      return (k < wr_cyc.size()) ? wr_cyc[k] : -1;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      int ac[6];
      int a, b, c, first, last, pc, r, bad;

      //            rst   data   rdy   full  | ack   fd     slwr  pktend
      vecs[0]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[1]  = '{1'b0, 8'hA1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 8'hB2, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 8'hB2, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 8'hB2, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};

      data       = 8'h00;
      data_rdy   = 1'b0;
      fx2_full_n = 1'b1;
      do_reset();
      check("fifoadr", 32'(fx2_fifoadr), 32'h2);

      for (int i = 0; i < 11; i++) begin
         reset      = vecs[i].rst;
         data       = vecs[i].d;
         data_rdy   = vecs[i].rdy;
         fx2_full_n = vecs[i].full_n;
         @(negedge clk);
         check($sformatf("vec%0d_ack", i), 32'(data_ack), 32'(vecs[i].ack));
         check($sformatf("vec%0d_fd", i), 32'(fx2_fd), 32'(vecs[i].fd));
         check($sformatf("vec%0d_slwr_n", i), 32'(fx2_slwr_n), 32'(vecs[i].slwr_n));
         check($sformatf("vec%0d_pktend_n", i), 32'(fx2_pktend_n), 32'(vecs[i].pktend_n));
         tick();
      end
      reset      = 1'b0;
      data_rdy   = 1'b0;
      fx2_full_n = 1'b1;

      // 6-byte record, then a single flush after the idle timeout.
      do_reset();
      clear_mon();
      for (int k = 0; k < 6; k++) send_byte(8'hA1 + 8'(k), ac[k]);
      data_rdy = 1'b0;
      for (int k = 1; k < 6; k++) check($sformatf("rec_ack_gap%0d", k), ac[k] - ac[k-1], 3);
      wait_pktend(0, 4 * FT, pc);
      check("rec_write_count", wr_q.size(), 6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rec_byte%0d", k), wr_at(k), 32'hA1 + k);
         check($sformatf("rec_write_cyc%0d", k), wr_cyc_at(k), ac[k] + 1);
      end
      // Ack, WRITE, RECOVER, FT counting IDLE cycles, then PKTEND.
      check("rec_flush_cycle", pc, ac[5] + 3 + FT);
      repeat (3 * FT) tick();
      check("rec_flush_count", pk_cyc.size(), 1);

      // One full packet back-to-back: auto-commit wrap, no PKTEND.
      clear_mon();
      first = -1;
      for (int i = 0; i < PKT_SIZE; i++) begin
         send_byte(8'(i), last);
         if (i == 0) first = last;
      end
      data_rdy = 1'b0;
      check("stream_span", last - first, 3 * (PKT_SIZE - 1));
      repeat (3 * FT) tick();
      check("stream_write_count", wr_q.size(), PKT_SIZE);
      bad = 0;
      for (int i = 0; i < PKT_SIZE; i++) if (wr_at(i) != (i % 256)) bad++;
      check("stream_bytes_bad", bad, 0);
      check("wrap_no_pktend", pk_cyc.size(), 0);
      for (int k = 0; k < 3; k++) send_byte(8'hE0 + 8'(k), last);
      data_rdy = 1'b0;
      wait_pktend(0, 4 * FT, pc);
      check("burst_flush_cycle", pc, last + 3 + FT);
      repeat (2 * FT) tick();
      check("burst_flush_count", pk_cyc.size(), 1);

      // FULL stall with a byte waiting, then FULL held across the flush timeout.
      clear_mon();
      send_byte(8'h30, a);
      send_byte(8'h31, a);
      data_rdy = 1'b0;
      tick();
      tick();
      fx2_full_n = 1'b0;
      data       = 8'h32;
      data_rdy   = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (data_ack !== 1'b0 || fx2_slwr_n !== 1'b1 || fx2_pktend_n !== 1'b1) bad++;
         tick();
      end
      check("stall_quiet_cycles", bad, 0);
      fx2_full_n = 1'b1;
      r = cyc;
      send_byte(8'h32, b);
      check("resume_ack_cycle", b, r);
      send_byte(8'h33, c);
      data_rdy   = 1'b0;
      fx2_full_n = 1'b0;
      repeat (FT + 12) tick();
      check("full_hold_no_pktend", pk_cyc.size(), 0);
      fx2_full_n = 1'b1;
      r = cyc;
      wait_pktend(0, 4 * FT, pc);
      check("full_release_flush_cycle", pc, r + 1);
      check("stall_write_count", wr_q.size(), 4);
      for (int k = 0; k < 4; k++) check($sformatf("stall_byte%0d", k), wr_at(k), 32'h30 + k);
      repeat (2 * FT) tick();
      check("stall_flush_count", pk_cyc.size(), 1);

      // Data arriving in the exact expiry cycle wins over the flush.
      clear_mon();
      send_byte(8'h40, a);
      data_rdy = 1'b0;
      while (cyc < a + 2 + FT) tick();
      send_byte(8'h41, b);
      data_rdy = 1'b0;
      check("collide_ack_cycle", b, a + 2 + FT);
      wait_pktend(0, 4 * FT, pc);
      check("collide_write_cycle", wr_cyc_at(1), b + 1);
      check("collide_flush_cycle", pc, b + 3 + FT);

      // Reset asserted for one cycle during a WRITE with a partial packet pending.
      repeat (4) tick();
      clear_mon();
      send_byte(8'h50, a);
      send_byte(8'h51, b);
      reset    = 1'b1;
      data_rdy = 1'b0;
      @(negedge clk);
      check("rst_pre_write_active", 32'(fx2_slwr_n), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_slwr_n", 32'(fx2_slwr_n), 32'd1);
      check("rst_pktend_n", 32'(fx2_pktend_n), 32'd1);
      check("rst_ack", 32'(data_ack), 32'd0);
      check("rst_fd", 32'(fx2_fd), 32'h00);
      tick();
      repeat (4 * FT) tick();
      check("rst_no_pktend", pk_cyc.size(), 0);
      check("rst_write_count", wr_q.size(), 2);

      // Long idle from reset: nothing is ever strobed.
      do_reset();
      clear_mon();
      repeat (10 * FT) tick();
      check("idle_no_pktend", pk_cyc.size(), 0);
      check("idle_no_write", wr_q.size(), 0);
      check("fifoadr_end", 32'(fx2_fifoadr), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
